req_grant_monitor: RTL and testbench
====================================

// Module: req_grant_monitor
// PURPOSE
//  Synthesizable multi-channel request/grant latency checker.
//  Per channel: once req is sampled high, gnt must follow within a [MIN_LAT, MAX_LAT] cycle window.
//  Reports per-channel pass/fail pulses, fail cause, busy and aggregate saturating counters.
//  Sits beside any req/gnt handshake; defaults reproduce a fixed "req |-> ##2 gnt" check.
// PARAMETERS
//  NUM_CH   4   number of independent req/gnt channels (>=1)
//  MIN_LAT  2   earliest legal grant latency in cycles (>=0)
//  MAX_LAT  2   latest legal grant latency in cycles (>=1, >=MIN_LAT; elaboration error otherwise)
//  CNT_W    16  width of pass/fail event counters
// PORTS
//  clk         in   1          single clock, all logic on posedge
//  rst_n       in   1          asynchronous active-low reset
//  en          in   1          checker enable; low forces all channels IDLE, counters hold
//  clr_cnt     in   1          synchronous clear of pass_cnt/fail_cnt/sticky_err
//  req         in   NUM_CH     per-channel request level
//  gnt         in   NUM_CH     per-channel grant level
//  busy        out  NUM_CH     channel has a check outstanding (WAIT state)
//  pass_pulse  out  NUM_CH     1-cycle pulse: grant arrived inside window
//  fail_pulse  out  NUM_CH     1-cycle pulse: check failed
//  fail_cause  out  3*NUM_CH   per-channel cause, valid with fail_pulse, else 0
//  pass_cnt    out  CNT_W      saturating total of pass events
//  fail_cnt    out  CNT_W      saturating total of fail events
//  sticky_err  out  1          set on any fail, held until clr_cnt or reset
// BEHAVIOUR
//  Reset: all outputs 0, all channels IDLE, latency counters 0.
//  Per-channel FSM IDLE/WAIT; latency counter width $clog2(MAX_LAT+2).
//  IDLE: edge with req=1,gnt=0 -> WAIT, lat=0 (edge k). gnt=1 && req=1 at edge k: latency 0,
//    pass if MIN_LAT==0 else fail EARLY. gnt=1 && req=0 -> fail SPURIOUS, stay IDLE.
//  WAIT: at edge k+n, lat=n. Evaluation order per edge (first match wins):
//    gnt=1 and n<MIN_LAT -> fail EARLY; gnt=1 and MIN_LAT<=n<=MAX_LAT -> pass;
//    req=0 -> fail DROP; n==MAX_LAT and gnt=0 -> fail TIMEOUT. Any decision -> IDLE.
//  Deciding edge returns to IDLE; a new check starts no earlier than the next edge.
//  Pulses/cause are registered: high for exactly the cycle after the deciding edge.
//  fail_cause: 0 NONE, 1 EARLY, 2 TIMEOUT, 3 SPURIOUS, 4 DROP.
//  Counters add popcount of same-cycle pulses, saturate at all-ones (no wrap).
//  clr_cnt coincident with events: clear wins, events of that cycle are discarded.
//  en=0: channels to IDLE on next edge, no pulses, busy=0; counters/sticky hold.
//  rst_n low mid-check: immediate return to reset values, no pulse emitted.
// CONFIGURATION
//  REQ_GNT_SVA_EN defined: per-channel concurrent assertions compiled in
//    (assert property on the same window, $display pass / $error fail with channel index),
//    disabled iff (!rst_n || !en); must agree cycle-for-cycle with pass/fail_pulse.
//  Undefined: pure synthesizable RTL, no assertions or $display/$error.
// STRUCTURE
//  Package req_grant_pkg: state_e {IDLE,WAIT}, fail_cause_e (3-bit enum above), CAUSE_W=3.
//  Sub-module req_grant_chan: one channel FSM + latency counter, generated NUM_CH times.
//  Top: generate loop, popcount, saturating counters, sticky_err.
// TESTING
//  Defaults; req0 rises at edge 3, gnt0 high at edge 5 -> pass_pulse[0] after edge 5, pass_cnt=1.
//  Defaults; req1 held, gnt1 never -> fail_pulse[1] cause=2 after edge k+2, sticky_err=1.
//  Defaults; gnt2 at lat 1 -> cause=1; gnt3 pulse with req3=0 in IDLE -> cause=3.
//  MIN_LAT=1,MAX_LAT=4; req drops at lat 2 -> cause=4; gnt at lat 4 -> pass.
//  All 4 channels pass same edge -> pass_cnt +4; CNT_W=3 preset to 6 -> saturates at 7.
//  rst_n low mid-WAIT, clr_cnt with fail same cycle, en=0 mid-WAIT -> no pulses, counts 0/held.

Source files
------------

// File: rtl/req_grant_pkg.sv
// ============================================================================
// Module      : req_grant_pkg
// Description : Shared types and constants for the req/gnt latency monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package req_grant_pkg;

    localparam int CAUSE_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_EARLY    = 3'd1,
        CAUSE_TIMEOUT  = 3'd2,
        CAUSE_SPURIOUS = 3'd3,
        CAUSE_DROP     = 3'd4
    } fail_cause_e;

endpackage

`default_nettype wire

// File: rtl/req_grant_chan.sv
// ============================================================================
// Module      : req_grant_chan
// Description : One req/gnt channel: IDLE/WAIT FSM, latency counter and
//               registered pass/fail pulses. REQ_GNT_SVA_EN adds assertions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_grant_chan
    import req_grant_pkg::*;
#(
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               req,
    input  logic               gnt,
    output logic               busy,
    output logic               pass_pulse,
    output logic               fail_pulse,
    output logic [CAUSE_W-1:0] fail_cause,
    output logic               pass_evt,
    output logic               fail_evt
);

    localparam int               LAT_W     = $clog2(MAX_LAT + 2);
    localparam logic [LAT_W-1:0] C_MAX_LAT = LAT_W'(MAX_LAT);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [LAT_W-1:0] r_lat;
    logic [LAT_W-1:0] w_lat_nxt;
    logic [LAT_W-1:0] w_lat_now;
    logic             w_pass;
    logic             w_fail;
    fail_cause_e      w_cause;
    logic             r_pass;
    logic             r_fail;
    fail_cause_e      r_cause;

    // r_lat counts completed cycles in WAIT; the edge being evaluated is one later
    assign w_lat_now = r_lat + LAT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_lat   <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_lat   <= w_lat_nxt;
            r_pass  <= w_pass;
            r_fail  <= w_fail;
            r_cause <= w_cause;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        if (!en) begin
            w_state_nxt = IDLE;
            w_lat_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req && !gnt) begin
                        w_state_nxt = WAIT;
                        w_lat_nxt   = '0;
                    end
                end
                WAIT: begin
                    if (w_pass || w_fail) begin
                        w_state_nxt = IDLE;
                        w_lat_nxt   = '0;
                    end else begin
                        w_lat_nxt   = w_lat_now;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_lat_nxt   = '0;
                end
            endcase
        end
    end

    // Decision for the current edge; order of the WAIT branches sets priority
    always_comb begin
        w_pass  = 1'b0;
        w_fail  = 1'b0;
        w_cause = CAUSE_NONE;
        if (en) begin
            case (r_state)
                IDLE: begin
                    if (gnt && req) begin
                        if (MIN_LAT == 0) begin
                            w_pass  = 1'b1;
                        end else begin
                            w_fail  = 1'b1;
                            w_cause = CAUSE_EARLY;
                        end
                    end else if (gnt) begin
                        w_fail  = 1'b1;
                        w_cause = CAUSE_SPURIOUS;
                    end
                end
                WAIT: begin
                    if (gnt && (int'(w_lat_now) < MIN_LAT)) begin
                        w_fail  = 1'b1;
                        w_cause = CAUSE_EARLY;
                    end else if (gnt) begin
                        w_pass  = 1'b1;
                    end else if (!req) begin
                        w_fail  = 1'b1;
                        w_cause = CAUSE_DROP;
                    end else if (w_lat_now == C_MAX_LAT) begin
                        w_fail  = 1'b1;
                        w_cause = CAUSE_TIMEOUT;
                    end
                end
                default: begin
                    w_pass  = 1'b0;
                end
            endcase
        end
    end

    assign busy       = (r_state == WAIT);
    assign pass_pulse = r_pass;
    assign fail_pulse = r_fail;
    assign fail_cause = r_cause;
    assign pass_evt   = w_pass;
    assign fail_evt   = w_fail;

`ifdef REQ_GNT_SVA_EN
    a_window: assert property (@(posedge clk) disable iff (!rst_n || !en) !w_fail)
        else $error("%m: req/gnt window check failed, cause %0d", $sampled(w_cause));

    always @(posedge clk) begin
        if (rst_n && en && w_pass) begin
            $display("%m: req/gnt window check passed");
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/req_grant_monitor.sv
// ============================================================================
// Module      : req_grant_monitor
// Description : Multi-channel req/gnt latency checker with saturating
//               pass/fail counters and sticky error. Macro: REQ_GNT_SVA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_grant_monitor
    import req_grant_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr_cnt,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         gnt,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         pass_pulse,
    output logic [NUM_CH-1:0]         fail_pulse,
    output logic [CAUSE_W*NUM_CH-1:0] fail_cause,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [CNT_W-1:0]          fail_cnt,
    output logic                      sticky_err
);

    localparam int               PC_W      = $clog2(NUM_CH + 1);
    localparam int               SUM_W     = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] C_CNT_MAX = SUM_W'({CNT_W{1'b1}});

    if (NUM_CH < 1 || MIN_LAT < 0 || MAX_LAT < 1 || MAX_LAT < MIN_LAT) begin : g_bad_params
        $error("req_grant_monitor: illegal NUM_CH/MIN_LAT/MAX_LAT combination");
    end

    logic [NUM_CH-1:0] w_pass_evt;
    logic [NUM_CH-1:0] w_fail_evt;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        req_grant_chan #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .req        (req[gi]),
            .gnt        (gnt[gi]),
            .busy       (busy[gi]),
            .pass_pulse (pass_pulse[gi]),
            .fail_pulse (fail_pulse[gi]),
            .fail_cause (fail_cause[gi*CAUSE_W +: CAUSE_W]),
            .pass_evt   (w_pass_evt[gi]),
            .fail_evt   (w_fail_evt[gi])
        );
    end

    logic [PC_W-1:0]  w_pass_pc;
    logic [PC_W-1:0]  w_fail_pc;
    logic [SUM_W-1:0] w_pass_sum;
    logic [SUM_W-1:0] w_fail_sum;
    logic [CNT_W-1:0] w_pass_sat;
    logic [CNT_W-1:0] w_fail_sat;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_sticky;

    // Counters track the deciding edge, so they move together with the pulses
    always_comb begin
        w_pass_pc = '0;
        w_fail_pc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pass_pc = w_pass_pc + PC_W'(w_pass_evt[i]);
            w_fail_pc = w_fail_pc + PC_W'(w_fail_evt[i]);
        end
        w_pass_sum = SUM_W'(r_pass_cnt) + SUM_W'(w_pass_pc);
        w_fail_sum = SUM_W'(r_fail_cnt) + SUM_W'(w_fail_pc);
        w_pass_sat = (w_pass_sum > C_CNT_MAX) ? {CNT_W{1'b1}} : w_pass_sum[CNT_W-1:0];
        w_fail_sat = (w_fail_sum > C_CNT_MAX) ? {CNT_W{1'b1}} : w_fail_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_sticky   <= 1'b0;
        end else if (clr_cnt) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_sticky   <= 1'b0;
        end else begin
            r_pass_cnt <= w_pass_sat;
            r_fail_cnt <= w_fail_sat;
            r_sticky   <= r_sticky | (|w_fail_evt);
        end
    end

    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;
    assign sticky_err = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_req_grant_monitor.sv
// ============================================================================
// Module      : tb_req_grant_monitor
// Description : Directed self-checking bench for req_grant_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_req_grant_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, clr_cnt;
    logic [3:0]  req, gnt, busy, pass_pulse, fail_pulse;
    logic [11:0] fail_cause;
    logic [15:0] pass_cnt, fail_cnt;
    logic        sticky_err;

    logic [0:0]  b_req, b_gnt, b_busy, b_pass, b_fail;
    logic [2:0]  b_cause;
    logic [7:0]  b_pass_cnt, b_fail_cnt;
    logic        b_sticky;

    logic [3:0]  c_req, c_gnt, c_busy, c_pass, c_fail;
    logic [11:0] c_cause;
    logic [2:0]  c_pass_cnt, c_fail_cnt;
    logic        c_sticky;

    int checks   = 0;
    int failures = 0;

    req_grant_monitor #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt), .req(req), .gnt(gnt),
        .busy(busy), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse), .fail_cause(fail_cause),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .sticky_err(sticky_err)
    );

    req_grant_monitor #(.NUM_CH(1), .MIN_LAT(1), .MAX_LAT(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt), .req(b_req), .gnt(b_gnt),
        .busy(b_busy), .pass_pulse(b_pass), .fail_pulse(b_fail), .fail_cause(b_cause),
        .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt), .sticky_err(b_sticky)
    );

    req_grant_monitor #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(2), .CNT_W(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt), .req(c_req), .gnt(c_gnt),
        .busy(c_busy), .pass_pulse(c_pass), .fail_pulse(c_fail), .fail_cause(c_cause),
        .pass_cnt(c_pass_cnt), .fail_cnt(c_fail_cnt), .sticky_err(c_sticky)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr_cnt = 1'b0;
        req = '0; gnt = '0; b_req = '0; b_gnt = '0; c_req = '0; c_gnt = '0;
        tick(); tick();
        checks++;
        if ({busy, pass_pulse, fail_pulse, fail_cause} !== 24'h0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", {busy, pass_pulse, fail_pulse, fail_cause});
        end
        checks++;
        if ({pass_cnt, fail_cnt, sticky_err} !== 33'h0) begin
            failures++; $display("FAIL reset_counters got=%h want=0", {pass_cnt, fail_cnt, sticky_err});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pass();
        req = 4'b0001; tick();
        checks++;
        if (busy !== 4'b0001) begin failures++; $display("FAIL pass_busy got=%b want=0001", busy); end
        tick();
        gnt = 4'b0001; tick();
        checks++;
        if (pass_pulse !== 4'b0001 || fail_pulse !== 4'b0000) begin
            failures++; $display("FAIL pass_pulse got=%b/%b want=0001/0000", pass_pulse, fail_pulse);
        end
        checks++;
        if (pass_cnt !== 16'd1 || busy !== 4'b0000 || fail_cause !== 12'h000) begin
            failures++; $display("FAIL pass_cnt got=%0d busy=%b cause=%h want=1/0000/000", pass_cnt, busy, fail_cause);
        end
        req = '0; gnt = '0; tick();
        checks++;
        if (pass_pulse !== 4'b0000 || pass_cnt !== 16'd1) begin
            failures++; $display("FAIL pass_one_cycle got=%b cnt=%0d want=0000/1", pass_pulse, pass_cnt);
        end
    endtask

    task automatic test_timeout();
        req = 4'b0010; tick(); tick();
        checks++;
        if (fail_pulse !== 4'b0000) begin failures++; $display("FAIL timeout_early_edge got=%b want=0000", fail_pulse); end
        tick();
        checks++;
        if (fail_pulse !== 4'b0010 || fail_cause !== 12'h010) begin
            failures++; $display("FAIL timeout_cause got=%b/%h want=0010/010", fail_pulse, fail_cause);
        end
        checks++;
        if (sticky_err !== 1'b1 || fail_cnt !== 16'd1) begin
            failures++; $display("FAIL timeout_sticky got=%b/%0d want=1/1", sticky_err, fail_cnt);
        end
        req = '0; tick();
        checks++;
        if (fail_pulse !== 4'b0000 || fail_cause !== 12'h000) begin
            failures++; $display("FAIL timeout_clear got=%b/%h want=0000/000", fail_pulse, fail_cause);
        end
    endtask

    task automatic test_early_spurious();
        req = 4'b0100; tick();
        gnt = 4'b0100; tick();
        checks++;
        if (fail_pulse !== 4'b0100 || fail_cause !== 12'h040) begin
            failures++; $display("FAIL early_lat1 got=%b/%h want=0100/040", fail_pulse, fail_cause);
        end
        req = '0; gnt = '0; tick();
        req = 4'b0100; gnt = 4'b0100; tick();
        checks++;
        if (fail_pulse !== 4'b0100 || fail_cause !== 12'h040 || busy !== 4'b0000) begin
            failures++; $display("FAIL early_lat0 got=%b/%h/%b want=0100/040/0000", fail_pulse, fail_cause, busy);
        end
        req = '0; gnt = 4'b1000; tick();
        checks++;
        if (fail_pulse !== 4'b1000 || fail_cause !== 12'h600) begin
            failures++; $display("FAIL spurious got=%b/%h want=1000/600", fail_pulse, fail_cause);
        end
        gnt = '0; tick();
        checks++;
        if (fail_cnt !== 16'd4 || pass_cnt !== 16'd1) begin
            failures++; $display("FAIL early_counts got=%0d/%0d want=4/1", fail_cnt, pass_cnt);
        end
    endtask

    task automatic test_all_pass();
        req = 4'b1111; tick(); tick();
        gnt = 4'b1111; tick();
        checks++;
        if (pass_pulse !== 4'b1111 || pass_cnt !== 16'd5) begin
            failures++; $display("FAIL all_pass got=%b/%0d want=1111/5", pass_pulse, pass_cnt);
        end
        req = '0; gnt = '0; tick();
    endtask

    task automatic test_reset_mid();
        req = 4'b0001; tick(); tick();
        rst_n = 1'b0; #1;
        checks++;
        if (busy !== 4'b0000 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || sticky_err !== 1'b0) begin
            failures++; $display("FAIL reset_mid_async got=%b/%0d/%0d/%b want=0000/0/0/0", busy, pass_cnt, fail_cnt, sticky_err);
        end
        gnt = 4'b0001; tick();
        checks++;
        if (pass_pulse !== 4'b0000 || fail_pulse !== 4'b0000) begin
            failures++; $display("FAIL reset_mid_pulse got=%b/%b want=0000/0000", pass_pulse, fail_pulse);
        end
        rst_n = 1'b1; req = '0; gnt = '0; tick();
        checks++;
        if (pass_pulse !== 4'b0000 || busy !== 4'b0000 || pass_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_mid_after got=%b/%b/%0d want=0000/0000/0", pass_pulse, busy, pass_cnt);
        end
    endtask

    task automatic test_clr_coincident();
        gnt = 4'b1000; tick();
        checks++;
        if (fail_cnt !== 16'd1 || sticky_err !== 1'b1) begin
            failures++; $display("FAIL clr_pre got=%0d/%b want=1/1", fail_cnt, sticky_err);
        end
        clr_cnt = 1'b1; tick();
        checks++;
        if (fail_pulse !== 4'b1000 || fail_cnt !== 16'd0 || sticky_err !== 1'b0) begin
            failures++; $display("FAIL clr_wins got=%b/%0d/%b want=1000/0/0", fail_pulse, fail_cnt, sticky_err);
        end
        gnt = '0; clr_cnt = 1'b0; tick();
        checks++;
        if (fail_cnt !== 16'd0 || pass_cnt !== 16'd0) begin
            failures++; $display("FAIL clr_after got=%0d/%0d want=0/0", fail_cnt, pass_cnt);
        end
    endtask

    task automatic test_en_low();
        gnt = 4'b1000; tick();
        gnt = '0; req = 4'b0010; tick();
        checks++;
        if (busy !== 4'b0010 || fail_cnt !== 16'd1) begin
            failures++; $display("FAIL en_pre got=%b/%0d want=0010/1", busy, fail_cnt);
        end
        en = 1'b0; tick();
        checks++;
        if (busy !== 4'b0000 || fail_pulse !== 4'b0000) begin
            failures++; $display("FAIL en_low_idle got=%b/%b want=0000/0000", busy, fail_pulse);
        end
        gnt = 4'b1010; tick(); tick();
        checks++;
        if (pass_pulse !== 4'b0000 || fail_pulse !== 4'b0000 || fail_cnt !== 16'd1 || sticky_err !== 1'b1) begin
            failures++; $display("FAIL en_low_hold got=%b/%b/%0d/%b want=0000/0000/1/1", pass_pulse, fail_pulse, fail_cnt, sticky_err);
        end
        req = '0; gnt = '0; en = 1'b1; tick();
    endtask

    task automatic test_wide_window();
        b_req = 1'b1; tick(); tick();
        b_req = 1'b0; tick();
        checks++;
        if (b_fail !== 1'b1 || b_cause !== 3'd4) begin
            failures++; $display("FAIL wide_drop got=%b/%0d want=1/4", b_fail, b_cause);
        end
        tick();
        b_req = 1'b1; tick(); tick(); tick(); tick();
        checks++;
        if (b_busy !== 1'b1 || b_fail !== 1'b0 || b_pass !== 1'b0) begin
            failures++; $display("FAIL wide_wait3 got=%b/%b/%b want=1/0/0", b_busy, b_fail, b_pass);
        end
        b_gnt = 1'b1; tick();
        checks++;
        if (b_pass !== 1'b1 || b_pass_cnt !== 8'd1 || b_fail_cnt !== 8'd1) begin
            failures++; $display("FAIL wide_pass_lat4 got=%b/%0d/%0d want=1/1/1", b_pass, b_pass_cnt, b_fail_cnt);
        end
        b_req = 1'b0; b_gnt = 1'b0; tick();
        b_req = 1'b1; b_gnt = 1'b1; tick();
        checks++;
        if (b_fail !== 1'b1 || b_cause !== 3'd1) begin
            failures++; $display("FAIL wide_early_lat0 got=%b/%0d want=1/1", b_fail, b_cause);
        end
        b_gnt = 1'b0; tick(); tick(); tick(); tick();
        checks++;
        if (b_fail !== 1'b0) begin failures++; $display("FAIL wide_no_timeout_lat3 got=%b want=0", b_fail); end
        tick();
        checks++;
        if (b_fail !== 1'b1 || b_cause !== 3'd2 || b_fail_cnt !== 8'd3) begin
            failures++; $display("FAIL wide_timeout got=%b/%0d/%0d want=1/2/3", b_fail, b_cause, b_fail_cnt);
        end
        b_req = 1'b0; tick();
    endtask

    task automatic test_saturate();
        c_req = 4'b1111; tick(); tick(); c_gnt = 4'b1111; tick();
        c_req = '0; c_gnt = '0; tick();
        checks++;
        if (c_pass_cnt !== 3'd4) begin failures++; $display("FAIL sat_four got=%0d want=4", c_pass_cnt); end
        c_req = 4'b0011; tick(); tick(); c_gnt = 4'b0011; tick();
        c_req = '0; c_gnt = '0; tick();
        checks++;
        if (c_pass_cnt !== 3'd6) begin failures++; $display("FAIL sat_six got=%0d want=6", c_pass_cnt); end
        c_req = 4'b1111; tick(); tick(); c_gnt = 4'b1111; tick();
        checks++;
        if (c_pass_cnt !== 3'd7 || c_pass !== 4'b1111) begin
            failures++; $display("FAIL sat_clamp got=%0d/%b want=7/1111", c_pass_cnt, c_pass);
        end
        c_req = '0; c_gnt = '0; tick();
        c_req = 4'b0001; tick(); tick(); c_gnt = 4'b0001; tick();
        checks++;
        if (c_pass_cnt !== 3'd7 || c_fail_cnt !== 3'd0) begin
            failures++; $display("FAIL sat_hold got=%0d/%0d want=7/0", c_pass_cnt, c_fail_cnt);
        end
        c_req = '0; c_gnt = '0; tick();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_timeout();
        test_early_spurious();
        test_all_pass();
        test_reset_mid();
        test_clr_coincident();
        test_en_low();
        test_wide_window();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
